dmem_port_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port data memory. It shares that memory between the pipeline MEM stage (core port) and the preload/debug loader (loader port). It grants one access per cycle, converts byte addresses to word indices, and rejects misaligned or out-of-range accesses. It also registers each response so that both requesters see read data with a fixed one-cycle latency.

---
 rtl/dmem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the pipeline MEM stage (core) and the
// preload/debug loader. Grants are combinational; responses are registered one cycle later.
module dmem_port_arbiter #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,

    input  logic        ld_req_i,
    input  logic        ld_we_i,
    input  logic [31:0] ld_addr_i,
    input  logic [31:0] ld_wdata_i,
    input  logic        ld_lock_i,
    output logic        ld_gnt_o,
    output logic        ld_rvalid_o,
    output logic [31:0] ld_rdata_o,
    output logic        ld_err_o,

    output logic        mem_write_o,
    output logic        mem_read_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    // Handshake: a request is accepted in the cycle where req and gnt are both high;
    // the response (rvalid pulse) follows exactly one cycle later and cannot be stalled.

    localparam int              CW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]   STARVE_MAX = CW'(STARVE_LIMIT);
    localparam logic [29:0]     DEPTH_W    = 30'(DEPTH);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;

    logic          core_sel;
    logic          ld_sel;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic [31:0]   rd_data;

    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_W);
    endfunction

    always_comb begin
        core_sel = 1'b0;
        ld_sel   = 1'b0;
        if (!rst_i) begin
            if (state == LOCKED) begin
                ld_sel = ld_req_i;
            end else if (ld_req_i && (starve_cnt == STARVE_MAX)) begin
                ld_sel = 1'b1;
            end else if (core_req_i) begin
                core_sel = 1'b1;
            end else if (ld_req_i) begin
                ld_sel = 1'b1;
            end
        end
    end

    // Winning access; all fields stay zero when nobody is granted so idle outputs are 0.
    always_comb begin
        acc_we    = 1'b0;
        acc_addr  = 32'h0;
        acc_wdata = 32'h0;
        if (core_sel) begin
            acc_we    = core_we_i;
            acc_addr  = core_addr_i;
            acc_wdata = core_wdata_i;
        end else if (ld_sel) begin
            acc_we    = ld_we_i;
            acc_addr  = ld_addr_i;
            acc_wdata = ld_wdata_i;
        end
    end

    assign acc_err     = (core_sel || ld_sel) && addr_err(acc_addr);
    assign core_gnt_o  = core_sel;
    assign ld_gnt_o    = ld_sel;
    assign mem_write_o = (core_sel || ld_sel) && acc_we && !acc_err;
    assign mem_read_o  = (core_sel || ld_sel) && !acc_we && !acc_err;
    assign mem_addr_o  = {2'b00, acc_addr[31:2]};
    assign mem_wdata_o = acc_wdata;
    assign rd_data     = mem_read_o ? mem_rdata_i : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ARB;
            starve_cnt    <= '0;
            core_rvalid_o <= 1'b0;
            core_rdata_o  <= 32'h0;
            core_err_o    <= 1'b0;
            ld_rvalid_o   <= 1'b0;
            ld_rdata_o    <= 32'h0;
            ld_err_o      <= 1'b0;
        end else begin
            case (state)
                ARB:     if (ld_sel && ld_lock_i) state <= LOCKED;
                LOCKED:  if (!ld_lock_i) state <= ARB;
                default: state <= ARB;
            endcase

            if (!ld_req_i || ld_sel) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + CW'(1);
            end

            core_rvalid_o <= core_sel;
            core_err_o    <= core_sel && acc_err;
            core_rdata_o  <= core_sel ? rd_data : 32'h0;
            ld_rvalid_o   <= ld_sel;
            ld_err_o      <= ld_sel && acc_err;
            ld_rdata_o    <= ld_sel ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port memory attached.
module tb_dmem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic        core_gnt_o, core_rvalid_o, core_err_o;
    logic [31:0] core_rdata_o;
    logic        ld_req_i, ld_we_i, ld_lock_i;
    logic [31:0] ld_addr_i, ld_wdata_i;
    logic        ld_gnt_o, ld_rvalid_o, ld_err_o;
    logic [31:0] ld_rdata_o;
    logic        mem_write_o, mem_read_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:1023];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_write_o) mem[mem_addr_o[9:0]] <= mem_wdata_o;
    end
    assign mem_rdata_i = mem[mem_addr_o[9:0]];

    dmem_port_arbiter #(.DEPTH(1024), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
        .ld_req_i(ld_req_i), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
        .ld_lock_i(ld_lock_i), .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
        .ld_rdata_o(ld_rdata_o), .ld_err_o(ld_err_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        core_req_i = req; core_we_i = we; core_addr_i = addr; core_wdata_i = wdata;
    endtask

    task automatic set_ld(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        ld_req_i = req; ld_we_i = we; ld_addr_i = addr; ld_wdata_i = wdata; ld_lock_i = lock;
    endtask

    task automatic idle();
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        set_core(1'b1, 1'b1, 32'h10, 32'h1);
        set_ld(1'b1, 1'b1, 32'h14, 32'h2, 1'b1);
        #1;
        checks++;
        if (core_gnt_o !== 1'b0 || ld_gnt_o !== 1'b0 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt got core=%0b ld=%0b we=%0b re=%0b exp all 0",
                     core_gnt_o, ld_gnt_o, mem_write_o, mem_read_o);
        end
        step();
        checks++;
        if (core_rvalid_o !== 1'b0 || ld_rvalid_o !== 1'b0 || core_err_o !== 1'b0 ||
            ld_err_o !== 1'b0 || core_rdata_o !== 32'h0 || ld_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp got crv=%0b lrv=%0b cerr=%0b lerr=%0b exp all 0",
                     core_rvalid_o, ld_rvalid_o, core_err_o, ld_err_o);
        end
        idle();
        rst_i = 1'b0;
        step();
    endtask

    task automatic test_core_rw();
        set_core(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
        #1;
        checks++;
        if (core_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0 || mem_addr_o !== 32'd4 ||
            mem_write_o !== 1'b1 || mem_read_o !== 1'b0 || mem_wdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL core_wr gnt=%0b addr=%h we=%0b re=%0b wd=%h exp 1/4/1/0/deadbeef",
                     core_gnt_o, mem_addr_o, mem_write_o, mem_read_o, mem_wdata_o);
        end
        step();
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        checks++;
        if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h0 || core_err_o !== 1'b0) begin
            errors++;
            $display("FAIL core_wr_resp rv=%0b rd=%h err=%0b exp 1/0/0",
                     core_rvalid_o, core_rdata_o, core_err_o);
        end
        checks++;
        if (core_gnt_o !== 1'b1 || mem_addr_o !== 32'd4 || mem_read_o !== 1'b1 || mem_write_o !== 1'b0) begin
            errors++;
            $display("FAIL core_rd gnt=%0b addr=%h re=%0b we=%0b exp 1/4/1/0",
                     core_gnt_o, mem_addr_o, mem_read_o, mem_write_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'hDEADBEEF || ld_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL core_rd_resp rv=%0b rd=%h ldrv=%0b exp 1/deadbeef/0",
                     core_rvalid_o, core_rdata_o, ld_rvalid_o);
        end
        checks++;
        if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs addr=%h wd=%h we=%0b re=%0b exp all 0",
                     mem_addr_o, mem_wdata_o, mem_write_o, mem_read_o);
        end
        step();
        checks++;
        if (core_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rvalid_pulse got=%0b exp=0", core_rvalid_o);
        end
    endtask

    task automatic test_contention();
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (core_gnt_o !== ((i % 5) != 4) || ld_gnt_o !== ((i % 5) == 4)) begin
                errors++;
                $display("FAIL contention_gnt cycle=%0d core=%0b ld=%0b exp core=%0b ld=%0b",
                         i, core_gnt_o, ld_gnt_o, ((i % 5) != 4), ((i % 5) == 4));
            end
            step();
            checks++;
            if (ld_rvalid_o !== ((i % 5) == 4) ||
                (ld_rvalid_o && ld_rdata_o !== 32'hDEADBEEF)) begin
                errors++;
                $display("FAIL contention_ld_resp cycle=%0d rv=%0b rd=%h exp rv=%0b rd=deadbeef",
                         i, ld_rvalid_o, ld_rdata_o, ((i % 5) == 4));
            end
        end
        idle();
        step();
    endtask

    task automatic test_lock();
        // Lock request without a loader grant must not lock.
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        step();
        set_ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (core_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_no_gnt core_gnt=%0b exp=1", core_gnt_o);
        end
        step();
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_ld(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
        #1;
        checks++;
        if (ld_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_enter ld_gnt=%0b exp=1", ld_gnt_o);
        end
        step();
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (core_gnt_o !== 1'b0 || ld_gnt_o !== 1'b1) begin
                errors++;
                $display("FAIL lock_hold cycle=%0d core=%0b ld=%0b exp 0/1", i, core_gnt_o, ld_gnt_o);
            end
            step();
        end
        set_ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        checks++;
        if (core_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_exit_cycle core_gnt=%0b exp=0", core_gnt_o);
        end
        step();
        checks++;
        if (core_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_exit core_gnt=%0b exp=1", core_gnt_o);
        end
        idle();
        step();
    endtask

    task automatic test_errors();
        set_core(1'b1, 1'b1, 32'h0, 32'hA5A5A5A5);
        step();
        set_core(1'b1, 1'b0, 32'h13, 32'h0);
        #1;
        checks++;
        if (core_gnt_o !== 1'b1 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL err_misaligned gnt=%0b we=%0b re=%0b exp 1/0/0",
                     core_gnt_o, mem_write_o, mem_read_o);
        end
        step();
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_ld(1'b1, 1'b1, 32'h1000, 32'hFFFFFFFF, 1'b0);
        #1;
        checks++;
        if (core_rvalid_o !== 1'b1 || core_err_o !== 1'b1 || core_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL err_core_resp rv=%0b err=%0b rd=%h exp 1/1/0",
                     core_rvalid_o, core_err_o, core_rdata_o);
        end
        checks++;
        if (ld_gnt_o !== 1'b1 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
            errors++;
            $display("FAIL err_range gnt=%0b we=%0b re=%0b exp 1/0/0",
                     ld_gnt_o, mem_write_o, mem_read_o);
        end
        step();
        set_ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (ld_rvalid_o !== 1'b1 || ld_err_o !== 1'b1 || ld_rdata_o !== 32'h0 ||
            mem[0] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL err_ld_resp rv=%0b err=%0b rd=%h mem0=%h exp 1/1/0/a5a5a5a5",
                     ld_rvalid_o, ld_err_o, ld_rdata_o, mem[0]);
        end
        step();
        set_core(1'b1, 1'b1, 32'hFFC, 32'hCAFEF00D);
        #1;
        checks++;
        if (core_rdata_o !== 32'hA5A5A5A5 || core_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_readback rd=%h err=%0b exp a5a5a5a5/0", core_rdata_o, core_err_o);
        end
        checks++;
        if (mem_write_o !== 1'b1 || mem_addr_o !== 32'd1023) begin
            errors++;
            $display("FAIL top_word_wr we=%0b addr=%h exp 1/3ff", mem_write_o, mem_addr_o);
        end
        step();
        set_core(1'b1, 1'b0, 32'hFFC, 32'h0);
        step();
        idle();
        #1;
        checks++;
        if (core_rdata_o !== 32'hCAFEF00D || core_err_o !== 1'b0) begin
            errors++;
            $display("FAIL top_word_rd rd=%h err=%0b exp cafef00d/0", core_rdata_o, core_err_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        set_core(1'b1, 1'b1, 32'h20, 32'h12345678);
        step();
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_ld(1'b1, 1'b1, 32'h20, 32'h00000BAD, 1'b0);
        rst_i = 1'b1;
        #1;
        checks++;
        if (ld_gnt_o !== 1'b0 || mem_write_o !== 1'b0 || core_rvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt ldgnt=%0b we=%0b crv=%0b exp 0/0/1",
                     ld_gnt_o, mem_write_o, core_rvalid_o);
        end
        step();
        rst_i = 1'b0;
        idle();
        #1;
        checks++;
        if (core_rvalid_o !== 1'b0 || core_rdata_o !== 32'h0 || ld_rvalid_o !== 1'b0 ||
            ld_err_o !== 1'b0 || mem[8] !== 32'h12345678) begin
            errors++;
            $display("FAIL rst_mid_after crv=%0b crd=%h lrv=%0b lerr=%0b mem8=%h exp 0/0/0/0/12345678",
                     core_rvalid_o, core_rdata_o, ld_rvalid_o, ld_err_o, mem[8]);
        end
        set_core(1'b1, 1'b0, 32'h20, 32'h0);
        step();
        idle();
        #1;
        checks++;
        if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h12345678) begin
            errors++;
            $display("FAIL rst_mid_readback rv=%0b rd=%h exp 1/12345678", core_rvalid_o, core_rdata_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        set_ld(1'b1, 1'b1, 32'h0, 32'h5, 1'b0);
        #1;
        checks++;
        if (ld_gnt_o !== 1'b1 || mem_write_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL b2b_ld_wr gnt=%0b we=%0b addr=%h exp 1/1/0", ld_gnt_o, mem_write_o, mem_addr_o);
        end
        step();
        set_ld(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_core(1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        checks++;
        if (core_gnt_o !== 1'b1 || ld_rvalid_o !== 1'b1 || ld_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL b2b_core_gnt gnt=%0b ldrv=%0b ldrd=%h exp 1/1/0",
                     core_gnt_o, ld_rvalid_o, ld_rdata_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (core_rvalid_o !== 1'b1 || core_rdata_o !== 32'h5 || ld_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_core_resp rv=%0b rd=%h ldrv=%0b exp 1/5/0",
                     core_rvalid_o, core_rdata_o, ld_rvalid_o);
        end
        step();
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        test_reset();
        test_core_rw();
        test_contention();
        test_lock();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
